// File: rtl/cut_stepper_driver_if.sv
// Cut-controller to blade-stepper link: run request and direction in, coil drive and angle out.
interface cut_stepper_driver_if;
   logic       en_i;
   logic       direction_i;
   logic [3:0] coil_o;
   logic       step_o;
   logic [8:0] position_o;
   logic       busy_o;

   modport master (
      output en_i, direction_i,
      input  coil_o, step_o, position_o, busy_o
   );

   modport slave (
      input  en_i, direction_i,
      output coil_o, step_o, position_o, busy_o
   );
endinterface

// File: rtl/cut_stepper_driver.sv
// Half-step driver for the 4-phase blade stepper: one step every STEP_CYCLES while en_i is high,
// coils held for HOLD_CYCLES after en_i falls; all outputs registered, no backpressure.
module cut_stepper_driver #(
   parameter int STEP_CYCLES = 500000,
   parameter int HOLD_CYCLES = 2500000,
   parameter int POS_STEPS   = 400
) (
   input logic                 clk,
   input logic                 rst,
   cut_stepper_driver_if.slave bus
);
   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_RUN    = 2'd1;
   localparam logic [1:0]  ST_HOLD   = 2'd2;
   localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 1);
   localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;
   localparam logic [8:0]  POS_LAST  = 9'(POS_STEPS - 1);

   logic [1:0]  state;
   logic [31:0] tick;
   logic [2:0]  phase;
   logic [8:0]  position;
   logic [3:0]  coil;
   logic        step;
   logic        busy;
   logic [2:0]  phase_nxt;
   logic [8:0]  pos_nxt;

   function automatic logic [3:0] half_step(input logic [2:0] p);
      case (p)
         3'd0:    half_step = 4'b1000;
         3'd1:    half_step = 4'b1100;
         3'd2:    half_step = 4'b0100;
         3'd3:    half_step = 4'b0110;
         3'd4:    half_step = 4'b0010;
         3'd5:    half_step = 4'b0011;
         3'd6:    half_step = 4'b0001;
         default: half_step = 4'b1001;
      endcase
   endfunction

   // Angle wraps on an explicit compare since POS_STEPS need not be a power of two.
   always_comb begin
      phase_nxt = phase;
      pos_nxt   = position;
      if (!bus.direction_i) begin
         phase_nxt = phase + 3'd1;
         pos_nxt   = (position == POS_LAST) ? 9'd0 : position + 9'd1;
      end else begin
         phase_nxt = phase - 3'd1;
         pos_nxt   = (position == 9'd0) ? POS_LAST : position - 9'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         tick     <= 32'd0;
         phase    <= 3'd0;
         position <= 9'd0;
         coil     <= 4'd0;
         step     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.en_i) begin
                  state <= ST_RUN;
                  tick  <= 32'd0;
                  coil  <= half_step(phase);
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               // Dropping en_i discards the partial step, even one due this very cycle.
               if (!bus.en_i) begin
                  tick <= 32'd0;
                  if (HOLD_CYCLES == 0) begin
                     state <= ST_IDLE;
                     coil  <= 4'd0;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_HOLD;
                  end
               end else if (tick == STEP_LAST) begin
                  tick     <= 32'd0;
                  step     <= 1'b1;
                  phase    <= phase_nxt;
                  position <= pos_nxt;
                  coil     <= half_step(phase_nxt);
               end else begin
                  tick <= tick + 32'd1;
               end
            end
            ST_HOLD: begin
               if (bus.en_i) begin
                  state <= ST_RUN;
                  tick  <= 32'd0;
               end else if (tick == HOLD_LAST) begin
                  state <= ST_IDLE;
                  tick  <= 32'd0;
                  coil  <= 4'd0;
                  busy  <= 1'b0;
               end else begin
                  tick <= tick + 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tick  <= 32'd0;
               coil  <= 4'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.coil_o     = coil;
   assign bus.step_o     = step;
   assign bus.position_o = position;
   assign bus.busy_o     = busy;
endmodule

// File: tb/tb_cut_stepper_driver.sv
// Directed bench for cut_stepper_driver with STEP_CYCLES=4, HOLD_CYCLES=6, POS_STEPS=400.
module tb_cut_stepper_driver;
   logic clk = 1'b0;
   logic rst;
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   step_count = 0;

   cut_stepper_driver_if bus ();

   cut_stepper_driver #(
      .STEP_CYCLES(4),
      .HOLD_CYCLES(6),
      .POS_STEPS  (400)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.step_o) step_count++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns the number of edges until step_o is seen, or -1 if none within limit.
   task automatic wait_step(input int limit, output int n);
      int   cnt;
      logic seen;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < limit) begin
         @(posedge clk);
         #1;
         cnt++;
         seen = bus.step_o;
      end
      n = seen ? cnt : -1;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int bad;
      int base;

      rst             = 1'b1;
      bus.en_i        = 1'b0;
      bus.direction_i = 1'b0;
      tick_clk(2);
      check_val("rst_coil", bus.coil_o, 4'b0000);
      check_val("rst_step", bus.step_o, 1'b0);
      check_val("rst_pos", bus.position_o, 9'd0);
      check_val("rst_busy", bus.busy_o, 1'b0);

      // Clockwise run from reset
      rst      = 1'b0;
      bus.en_i = 1'b1;
      base     = step_count;
      tick_clk(1);
      check_val("start_coil", bus.coil_o, 4'b1000);
      check_val("start_busy", bus.busy_o, 1'b1);
      check_val("start_nostep", bus.step_o, 1'b0);
      wait_step(10, n);
      check_val("first_step_lat", n, 4);
      check_val("first_step_coil", bus.coil_o, 4'b1100);
      check_val("first_step_pos", bus.position_o, 9'd1);
      tick_clk(1);
      check_val("step_width", bus.step_o, 1'b0);
      wait_step(10, n);
      check_val("second_step_lat", n, 3);
      check_val("second_step_coil", bus.coil_o, 4'b0100);
      bad = 0;
      for (int i = 0; i < 98; i++) begin
         wait_step(10, n);
         if (n != 4) bad++;
      end
      check_val("cw_period", bad, 0);
      check_val("cw100_pos", bus.position_o, 9'd100);
      check_val("cw100_coil", bus.coil_o, 4'b0010);

      // Counter-clockwise back to zero
      bus.direction_i = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         wait_step(10, n);
         if (n != 4) bad++;
      end
      check_val("ccw_period", bad, 0);
      check_val("ccw100_pos", bus.position_o, 9'd0);
      check_val("ccw100_coil", bus.coil_o, 4'b1000);
      tick_clk(1);
      check_val("step_pulses", step_count - base, 200);

      // Wrap below zero and back
      rst      = 1'b1;
      bus.en_i = 1'b0;
      tick_clk(2);
      rst      = 1'b0;
      bus.en_i = 1'b1;
      tick_clk(1);
      wait_step(10, n);
      check_val("wrap_dn_lat", n, 4);
      check_val("wrap_dn_pos", bus.position_o, 9'd399);
      check_val("wrap_dn_coil", bus.coil_o, 4'b1001);
      bus.direction_i = 1'b0;
      wait_step(10, n);
      check_val("wrap_up_pos", bus.position_o, 9'd0);
      check_val("wrap_up_coil", bus.coil_o, 4'b1000);

      // en_i drops two cycles into a step
      tick_clk(2);
      bus.en_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick_clk(1);
         check_val("hold_coil", bus.coil_o, 4'b1000);
         check_val("hold_nostep", bus.step_o, 1'b0);
      end
      tick_clk(1);
      check_val("hold_expire_coil", bus.coil_o, 4'b0000);
      check_val("hold_expire_busy", bus.busy_o, 1'b0);
      check_val("hold_expire_pos", bus.position_o, 9'd0);

      // Re-raise en_i during HOLD
      bus.en_i = 1'b1;
      tick_clk(1);
      check_val("reen_coil", bus.coil_o, 4'b1000);
      wait_step(10, n);
      check_val("reen_step_pos", bus.position_o, 9'd1);
      tick_clk(2);
      bus.en_i = 1'b0;
      tick_clk(3);
      check_val("mid_hold_coil", bus.coil_o, 4'b1100);
      bus.en_i = 1'b1;
      tick_clk(1);
      check_val("rerun_coil", bus.coil_o, 4'b1100);
      check_val("rerun_busy", bus.busy_o, 1'b1);
      wait_step(10, n);
      check_val("rerun_lat", n, 4);
      check_val("rerun_pos", bus.position_o, 9'd2);
      check_val("rerun_coil_step", bus.coil_o, 4'b0100);

      // en_i falls on the cycle a step is due
      tick_clk(3);
      bus.en_i = 1'b0;
      tick_clk(1);
      check_val("due_nostep", bus.step_o, 1'b0);
      check_val("due_pos", bus.position_o, 9'd2);
      check_val("due_coil", bus.coil_o, 4'b0100);
      tick_clk(6);
      check_val("due_idle_coil", bus.coil_o, 4'b0000);

      // Direction toggled mid-step
      bus.en_i = 1'b1;
      tick_clk(3);
      bus.direction_i = 1'b1;
      wait_step(10, n);
      check_val("dir_toggle_lat", n, 2);
      check_val("dir_toggle_pos", bus.position_o, 9'd1);
      check_val("dir_toggle_coil", bus.coil_o, 4'b1100);

      // Async reset mid-run at position 37
      bus.direction_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 36; i++) begin
         wait_step(10, n);
         if (n != 4) bad++;
      end
      check_val("to37_period", bad, 0);
      check_val("to37_pos", bus.position_o, 9'd37);
      check_val("to37_coil", bus.coil_o, 4'b0011);
      tick_clk(1);
      rst = 1'b1;
      #1;
      check_val("arst_coil", bus.coil_o, 4'b0000);
      check_val("arst_step", bus.step_o, 1'b0);
      check_val("arst_pos", bus.position_o, 9'd0);
      check_val("arst_busy", bus.busy_o, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick_clk(1);
      check_val("post_rst_coil", bus.coil_o, 4'b1000);
      check_val("post_rst_pos", bus.position_o, 9'd0);
      wait_step(10, n);
      check_val("post_rst_lat", n, 4);
      check_val("post_rst_step_pos", bus.position_o, 9'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
